// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. Holds the program counter, fetches one word at a
// time from instruction memory over a req/ready/rvalid handshake and presents
// the fetched word to the decoder for one execute cycle (longer when the
// datapath stalls). The next PC is chosen from the decoder's Branch/Jump/Jalr
// controls. A misaligned next PC latches a sticky fault and parks the unit in
// HALT until reset.
//
// Ports
//   clk, reset        : clock and synchronous active-high reset
//   Branch/Jump/Jalr  : control-flow controls, only looked at in EXEC
//   ImmExt            : PC-relative offset for branch / jal targets
//   ALUResult         : rs1+imm, the jalr target before bit-0 clearing
//   stall             : hold the current instruction in EXEC
//   imem_req/addr     : fetch request; addr always mirrors PC
//   imem_ready        : memory accepted the request (REQ only)
//   imem_rvalid/rdata : fetched word (WAIT only)
//   Instr, PC, PCPlus4: current instruction, its address, link value
//   instr_valid       : Instr is executable this cycle
//   fault, fault_addr : sticky misaligned-target flag and offending target
//
// RESET_PC must be 4-byte aligned.
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        Jalr,
    input  logic [31:0] ImmExt,
    input  logic [31:0] ALUResult,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        instr_valid,
    output logic        fault,
    output logic [31:0] fault_addr
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_EXEC,
        S_HALT
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        req_q;
    logic        valid_q;
    logic        fault_q;
    logic [31:0] fault_addr_q;

    logic [31:0] pc_plus4;
    logic [31:0] branch_tgt;
    logic [31:0] jalr_tgt;
    logic [31:0] target_d;

    // Next-PC candidates; all adds wrap modulo 2^32.
    always_comb begin
        pc_plus4   = pc_q + 32'd4;
        branch_tgt = pc_q + ImmExt;
        jalr_tgt   = {ALUResult[31:1], 1'b0};
        // Jalr wins over Branch/Jump.
        if (Jalr) begin
            target_d = jalr_tgt;
        end else if (Branch || Jump) begin
            target_d = branch_tgt;
        end else begin
            target_d = pc_plus4;
        end
    end

    // Single-process FSM. imem_req and instr_valid are registered alongside
    // the state so that no imem_* input reaches an output combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            instr_q      <= NOP;
            req_q        <= 1'b0;
            valid_q      <= 1'b0;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'h0000_0000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_REQ;
                    req_q   <= 1'b1;
                end
                S_REQ: begin
                    // Request and address held stable until accepted.
                    if (imem_ready) begin
                        state_q <= S_WAIT;
                        req_q   <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        instr_q <= imem_rdata;
                        state_q <= S_EXEC;
                        valid_q <= 1'b1;
                    end
                end
                S_EXEC: begin
                    // While stalled everything holds, including instr_valid.
                    if (!stall) begin
                        valid_q <= 1'b0;
                        if (target_d[1:0] == 2'b00) begin
                            pc_q    <= target_d;
                            state_q <= S_REQ;
                            req_q   <= 1'b1;
                        end else begin
                            // PC stays on the faulting instruction.
                            fault_q      <= 1'b1;
                            fault_addr_q <= target_d;
                            state_q      <= S_HALT;
                        end
                    end
                end
                S_HALT: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign Instr       = instr_q;
    assign PC          = pc_q;
    assign PCPlus4     = pc_plus4;
    assign instr_valid = valid_q;
    assign fault       = fault_q;
    assign fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. A table of per-cycle records holds the
// inputs applied for the coming edge and the outputs expected in the current
// cycle; it walks sequential fetch, branches, jal/jalr priority, a misaligned
// branch into HALT and reset out of HALT. Hand-written sequences then cover
// handshake wait states, a 4-cycle stall, PC wrap and reset during WAIT.
// Outputs are checked on the falling edge; inputs change there too.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        Branch;
    logic        Jump;
    logic        Jalr;
    logic [31:0] ImmExt;
    logic [31:0] ALUResult;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        instr_valid;
    logic        fault;
    logic [31:0] fault_addr;

    int n_vec  = 0;
    int n_fail = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .Branch     (Branch),
        .Jump       (Jump),
        .Jalr       (Jalr),
        .ImmExt     (ImmExt),
        .ALUResult  (ALUResult),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .Instr      (Instr),
        .PC         (PC),
        .PCPlus4    (PCPlus4),
        .instr_valid(instr_valid),
        .fault      (fault),
        .fault_addr (fault_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        br;
        logic        jp;
        logic        jr;
        logic [31:0] imm;
        logic [31:0] alu;
        logic        stl;
        logic        e_req;
        logic        e_valid;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic        e_fault;
        logic [31:0] e_faddr;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] iw(input int k);
        return 32'hA000_0000 | k;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic rst, input logic rdy, input logic rv, input logic [31:0] rdata,
                        input logic br, input logic jp, input logic jr,
                        input logic [31:0] imm, input logic [31:0] alu, input logic stl,
                        input logic e_req, input logic e_valid, input logic [31:0] e_addr,
                        input logic [31:0] e_instr, input logic e_fault, input logic [31:0] e_faddr);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rv = rv; v.rdata = rdata;
        v.br = br; v.jp = jp; v.jr = jr; v.imm = imm; v.alu = alu; v.stl = stl;
        v.e_req = e_req; v.e_valid = e_valid; v.e_addr = e_addr;
        v.e_instr = e_instr; v.e_fault = e_fault; v.e_faddr = e_faddr;
        tbl.push_back(v);
    endtask

    // One zero-wait instruction: REQ, WAIT, EXEC rows. Controls are also driven
    // in REQ/WAIT and junk rdata/rvalid in REQ/EXEC; all of that must be ignored.
    task automatic fetch3(input logic [31:0] addr, input logic [31:0] prev, input logic [31:0] rdata,
                          input logic br, input logic jp, input logic jr,
                          input logic [31:0] imm, input logic [31:0] alu);
        push(0, 1, 1, 32'hDEAD_BEEF, br, jp, jr, imm, alu, 0, 1, 0, addr, prev,  0, 32'h0);
        push(0, 1, 1, rdata,         br, jp, jr, imm, alu, 0, 0, 0, addr, prev,  0, 32'h0);
        push(0, 1, 1, 32'hBAD0_0BAD, br, jp, jr, imm, alu, 0, 0, 1, addr, rdata, 0, 32'h0);
    endtask

    task automatic idle_inputs();
        Branch = 0; Jump = 0; Jalr = 0; ImmExt = 0; ALUResult = 0; stall = 0;
        imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();

        // ---------------- table ----------------
        push(0, 1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, NOP, 0, 32'h0); // IDLE
        fetch3(32'h000, NOP,    iw(0),  0, 0, 0, 32'h0,        32'h0);
        fetch3(32'h004, iw(0),  iw(1),  0, 0, 0, 32'h0,        32'h0);
        fetch3(32'h008, iw(1),  iw(2),  0, 0, 0, 32'h0,        32'h0);
        fetch3(32'h00C, iw(2),  iw(3),  0, 0, 0, 32'h0,        32'h0);
        fetch3(32'h010, iw(3),  iw(4),  0, 0, 0, 32'hFFFF_FFF8, 32'h0);   // not taken -> 0x14
        fetch3(32'h014, iw(4),  iw(5),  1, 0, 0, 32'hFFFF_FFFC, 32'h0);   // -> 0x10
        fetch3(32'h010, iw(5),  iw(6),  1, 0, 0, 32'hFFFF_FFF8, 32'h0);   // taken -> 0x08
        fetch3(32'h008, iw(6),  iw(7),  0, 1, 0, 32'h18,        32'h0);   // jal -> 0x20
        fetch3(32'h020, iw(7),  iw(8),  0, 1, 0, 32'h100,       32'h0);   // jal -> 0x120
        fetch3(32'h120, iw(8),  iw(9),  0, 1, 1, 32'h4,         32'h205); // jalr wins -> 0x204
        fetch3(32'h204, iw(9),  iw(10), 1, 0, 1, 32'h8,         32'h40);  // jalr wins -> 0x40
        fetch3(32'h040, iw(10), iw(11), 1, 0, 0, 32'h6,         32'h0);   // -> 0x46 misaligned
        push(0, 1, 1, 32'h1234_5678, 1, 1, 1, 32'h0, 32'h0, 0, 0, 0, 32'h40, iw(11), 1, 32'h46); // HALT
        push(0, 1, 1, 32'h1234_5678, 1, 1, 1, 32'h0, 32'h0, 0, 0, 0, 32'h40, iw(11), 1, 32'h46); // HALT
        push(1, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h40, iw(11), 1, 32'h46);         // reset in HALT
        push(0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, NOP, 0, 32'h0);              // IDLE
        push(0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0, 32'h0, NOP, 0, 32'h0);              // REQ

        repeat (2) @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            $display("row %0d: req=%b addr=%h valid=%b instr=%h fault=%b faddr=%h",
                     i, imem_req, imem_addr, instr_valid, Instr, fault, fault_addr);
            chk($sformatf("row%0d imem_req", i),    imem_req,    tbl[i].e_req);
            chk($sformatf("row%0d imem_addr", i),   imem_addr,   tbl[i].e_addr);
            chk($sformatf("row%0d PC", i),          PC,          tbl[i].e_addr);
            chk($sformatf("row%0d PCPlus4", i),     PCPlus4,     tbl[i].e_addr + 32'd4);
            chk($sformatf("row%0d instr_valid", i), instr_valid, tbl[i].e_valid);
            chk($sformatf("row%0d Instr", i),       Instr,       tbl[i].e_instr);
            chk($sformatf("row%0d fault", i),       fault,       tbl[i].e_fault);
            chk($sformatf("row%0d fault_addr", i),  fault_addr,  tbl[i].e_faddr);
            reset      = tbl[i].rst;
            imem_ready = tbl[i].rdy;
            imem_rvalid = tbl[i].rv;
            imem_rdata = tbl[i].rdata;
            Branch     = tbl[i].br;
            Jump       = tbl[i].jp;
            Jalr       = tbl[i].jr;
            ImmExt     = tbl[i].imm;
            ALUResult  = tbl[i].alu;
            stall      = tbl[i].stl;
        end

        // ---------------- handshake waits and stall ----------------
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        chk("waits reset req", imem_req, 1'b0);
        chk("waits reset PC", PC, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("waits req rises", imem_req, 1'b1);
        chk("waits req addr", imem_addr, 32'h0);
        repeat (2) begin
            @(negedge clk);
            chk("notready req held", imem_req, 1'b1);
            chk("notready addr held", imem_addr, 32'h0);
            chk("notready valid", instr_valid, 1'b0);
        end
        imem_ready = 1'b1;
        @(negedge clk);
        chk("wait req low", imem_req, 1'b0);
        imem_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("late rvalid valid", instr_valid, 1'b0);
            chk("late rvalid req", imem_req, 1'b0);
            chk("late rvalid addr", imem_addr, 32'h0);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h00A0_0093;
        @(negedge clk);
        chk("waits exec valid", instr_valid, 1'b1);
        chk("waits exec Instr", Instr, 32'h00A0_0093);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        stall  = 1'b1;
        Branch = 1'b1;
        ImmExt = 32'h8;
        repeat (4) begin
            @(negedge clk);
            chk("stall valid", instr_valid, 1'b1);
            chk("stall no req", imem_req, 1'b0);
            chk("stall PC", PC, 32'h0);
            chk("stall Instr", Instr, 32'h00A0_0093);
        end
        stall  = 1'b0;
        Branch = 1'b0;
        ImmExt = 32'h0;
        @(negedge clk);
        chk("after stall req", imem_req, 1'b1);
        chk("after stall addr", imem_addr, 32'h4);
        chk("after stall valid", instr_valid, 1'b0);

        // ---------------- wrap through 0xFFFF_FFFC ----------------
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_8067;
        @(negedge clk);
        chk("jalr exec PC", PC, 32'h4);
        imem_rvalid = 1'b0;
        Jalr      = 1'b1;
        ALUResult = 32'hFFFF_FFFD;
        @(negedge clk);
        chk("jalr to top addr", imem_addr, 32'hFFFF_FFFC);
        chk("jalr to top fault", fault, 1'b0);
        Jalr      = 1'b0;
        ALUResult = 32'h0;
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0010_0013;
        @(negedge clk);
        chk("top PCPlus4 wraps", PCPlus4, 32'h0);
        chk("top Instr", Instr, 32'h0010_0013);
        imem_rvalid = 1'b0;
        @(negedge clk);
        chk("wrap addr", imem_addr, 32'h0);
        chk("wrap req", imem_req, 1'b1);
        chk("wrap fault", fault, 1'b0);

        // ---------------- reset during WAIT ----------------
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0020_0013;
        @(negedge clk);
        imem_rvalid = 1'b0;
        @(negedge clk);
        chk("pre-reset addr", imem_addr, 32'h4);
        imem_ready = 1'b1;
        @(negedge clk);
        chk("pre-reset in wait", imem_req, 1'b0);
        imem_ready  = 1'b0;
        reset       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0030_0013;
        @(negedge clk);
        chk("rst wait PC", PC, 32'h0);
        chk("rst wait fault", fault, 1'b0);
        chk("rst wait valid", instr_valid, 1'b0);
        chk("rst wait req", imem_req, 1'b0);
        chk("rst wait Instr", Instr, NOP);
        reset       = 1'b0;
        imem_rvalid = 1'b0;
        @(negedge clk);
        chk("rst wait req rises", imem_req, 1'b1);
        chk("rst wait addr", imem_addr, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
